hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding unit and decides what forwarding cannot solve: load-use and branch-in-ID operand hazards, taken-branch flush, multi-cycle mul/div occupancy of EX, and data-memory wait states. Its outputs are the write enables and bubble/flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus a stall performance counter.

---
 rtl/mips_pipe_pkg.sv | 15 +
 rtl/md_busy_timer.sv | 29 ++
 rtl/hazard_stall_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the 5-stage MIPS pipeline control blocks.
// Holds the sequencing-state encoding, the register-index width and the mul/div default latency.
package mips_pipe_pkg;

  localparam int REG_W          = 5;
  localparam int MD_LATENCY_DEF = 4;
  localparam int MD_CNT_W       = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/md_busy_timer.sv
// Loadable saturating down-counter that tracks the remaining mul/div occupancy of EX.
// Load has priority over tick; the count takes effect on the next clock and holds at zero.
module md_busy_timer
  import mips_pipe_pkg::*;
#(
  parameter int W = MD_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use / branch-operand stalls, branch flush, mul/div EX occupancy, dmem wait.
// Controls are combinational from state and inputs (zero latency); a pending memory access freezes everything up to MEM/WB.
module hazard_stall_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_Rs,
  input  logic [REG_W-1:0] id_Rt,
  input  logic             id_usesRt,
  input  logic             id_isBranch,
  input  logic             id_isMulDiv,
  input  logic             branchTaken,
  input  logic             id_exMemRead,
  input  logic             id_exRegWrite,
  input  logic [REG_W-1:0] id_exRd,
  input  logic             ex_memMemRead,
  input  logic             ex_memMemWrite,
  input  logic [REG_W-1:0] ex_memRd,
  input  logic             dmem_ready,
  output logic             pcWrite,
  output logic             if_idWrite,
  output logic             if_idFlush,
  output logic             id_exWrite,
  output logic             id_exBubble,
  output logic             ex_memWrite,
  output logic             ex_memBubble,
  output logic             mem_wbBubble,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [MD_CNT_W-1:0] MD_RELOAD = MD_CNT_W'(MD_LATENCY - 1);
  localparam bit                  MD_MULTI  = (MD_LATENCY > 1);

  pipe_state_e         state, state_nxt;
  logic                md_pend, md_pend_nxt;
  logic [MD_CNT_W-1:0] md_cnt;
  logic                md_zero;
  logic                md_load;
  logic                md_tick;
  logic                lu, br_ex, br_mem, stall_id, mem_hold;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign lu = id_exMemRead && (id_exRd != '0) &&
              ((id_exRd == id_Rs) || (id_usesRt && (id_exRd == id_Rt)));
  assign br_ex = id_isBranch && id_exRegWrite && (id_exRd != '0) &&
                 ((id_exRd == id_Rs) || (id_exRd == id_Rt));
  assign br_mem = id_isBranch && ex_memMemRead && (ex_memRd != '0) &&
                  ((ex_memRd == id_Rs) || (ex_memRd == id_Rt));
  assign stall_id = lu || br_ex || br_mem;
  assign mem_hold = (ex_memMemRead || ex_memMemWrite) && !dmem_ready;

  always_comb begin
    pcWrite      = 1'b1;
    if_idWrite   = 1'b1;
    if_idFlush   = 1'b0;
    id_exWrite   = 1'b1;
    id_exBubble  = 1'b0;
    ex_memWrite  = 1'b1;
    ex_memBubble = 1'b0;
    mem_wbBubble = 1'b0;
    md_start     = 1'b0;
    md_load      = 1'b0;
    state_nxt    = state;
    md_pend_nxt  = md_pend;

    if (mem_hold) begin
      pcWrite      = 1'b0;
      if_idWrite   = 1'b0;
      id_exWrite   = 1'b0;
      ex_memWrite  = 1'b0;
      mem_wbBubble = 1'b1;
      state_nxt    = MEM_WAIT;
      md_pend_nxt  = (state == MD_BUSY) || ((state == MEM_WAIT) && md_pend);
    end else begin
      case (state)
        MEM_WAIT: begin
          state_nxt = (md_pend && !md_zero) ? MD_BUSY : RUN;
        end
        MD_BUSY: begin
          pcWrite      = 1'b0;
          if_idWrite   = 1'b0;
          id_exWrite   = 1'b0;
          ex_memBubble = 1'b1;
          // Leave as the count reaches zero so the following RUN cycle releases the result.
          if (md_zero || (md_cnt == MD_CNT_W'(1))) begin
            state_nxt = RUN;
          end
        end
        default: begin
          if (stall_id) begin
            pcWrite     = 1'b0;
            if_idWrite  = 1'b0;
            id_exBubble = 1'b1;
          end else begin
            if_idFlush = branchTaken;
            if (id_isMulDiv) begin
              md_start  = 1'b1;
              md_load   = MD_MULTI;
              state_nxt = MD_MULTI ? MD_BUSY : RUN;
            end
          end
        end
      endcase
    end
  end

  assign md_tick = (state != RUN);
  assign md_busy = (state == MD_BUSY);

  md_busy_timer #(
    .W(MD_CNT_W)
  ) u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (md_load),
    .load_val (MD_RELOAD),
    .tick     (md_tick),
    .cnt      (md_cnt),
    .zero     (md_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      md_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      md_pend <= md_pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (!pcWrite && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed hazard scenarios then random traffic against a cycle-level reference model.
module tb_hazard_stall_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_Rs, id_Rt, id_exRd, ex_memRd;
  logic          id_usesRt, id_isBranch, id_isMulDiv, branchTaken;
  logic          id_exMemRead, id_exRegWrite, ex_memMemRead, ex_memMemWrite, dmem_ready;
  logic          pcWrite, if_idWrite, if_idFlush, id_exWrite, id_exBubble;
  logic          ex_memWrite, ex_memBubble, mem_wbBubble, md_start, md_busy;
  logic [CW-1:0] stall_cycles;
  logic [9:0]    ctrl_obs;

  int checks   = 0;
  int failures = 0;

  // Reference model state: remaining mul/div count, busy/waiting flags, stall tally.
  int m_cnt, m_stalls, n_cnt, n_stalls;
  bit m_busy, m_wait, m_pend, n_busy, n_wait, n_pend;
  logic [9:0] e_ctrl;

  hazard_stall_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_Rs(id_Rs), .id_Rt(id_Rt), .id_usesRt(id_usesRt), .id_isBranch(id_isBranch),
    .id_isMulDiv(id_isMulDiv), .branchTaken(branchTaken),
    .id_exMemRead(id_exMemRead), .id_exRegWrite(id_exRegWrite), .id_exRd(id_exRd),
    .ex_memMemRead(ex_memMemRead), .ex_memMemWrite(ex_memMemWrite), .ex_memRd(ex_memRd),
    .dmem_ready(dmem_ready),
    .pcWrite(pcWrite), .if_idWrite(if_idWrite), .if_idFlush(if_idFlush),
    .id_exWrite(id_exWrite), .id_exBubble(id_exBubble), .ex_memWrite(ex_memWrite),
    .ex_memBubble(ex_memBubble), .mem_wbBubble(mem_wbBubble), .md_start(md_start),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {pcWrite, if_idWrite, if_idFlush, id_exWrite, id_exBubble,
                     ex_memWrite, ex_memBubble, mem_wbBubble, md_start, md_busy};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_Rs = '0; id_Rt = '0; id_exRd = '0; ex_memRd = '0;
    id_usesRt = 1'b0; id_isBranch = 1'b0; id_isMulDiv = 1'b0; branchTaken = 1'b0;
    id_exMemRead = 1'b0; id_exRegWrite = 1'b0;
    ex_memMemRead = 1'b0; ex_memMemWrite = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic model_clear();
    m_cnt = 0; m_stalls = 0; m_busy = 1'b0; m_wait = 1'b0; m_pend = 1'b0;
  endtask

  task automatic model_eval();
    bit hold, stall;
    bit pw, iw, fl, ew, eb, mw, mb, wb, st;
    hold  = (ex_memMemRead || ex_memMemWrite) && !dmem_ready;
    stall = (id_exMemRead && id_exRd != 0 &&
             (id_exRd == id_Rs || (id_usesRt && id_exRd == id_Rt))) ||
            (id_isBranch && id_exRegWrite && id_exRd != 0 && (id_exRd == id_Rs || id_exRd == id_Rt)) ||
            (id_isBranch && ex_memMemRead && ex_memRd != 0 && (ex_memRd == id_Rs || ex_memRd == id_Rt));
    pw = 1; iw = 1; fl = 0; ew = 1; eb = 0; mw = 1; mb = 0; wb = 0; st = 0;
    n_cnt  = (m_busy || m_wait) ? ((m_cnt > 0) ? m_cnt - 1 : 0) : m_cnt;
    n_busy = m_busy; n_wait = m_wait; n_pend = m_pend;
    if (hold) begin
      pw = 0; iw = 0; ew = 0; mw = 0; wb = 1;
      n_pend = m_busy || (m_wait && m_pend);
      n_wait = 1; n_busy = 0;
    end else if (m_wait) begin
      n_wait = 0;
      n_busy = m_pend && (m_cnt != 0);
    end else if (m_busy) begin
      pw = 0; iw = 0; ew = 0; mb = 1;
      n_busy = (n_cnt != 0);
    end else if (stall) begin
      pw = 0; iw = 0; eb = 1;
    end else begin
      fl = branchTaken;
      if (id_isMulDiv) begin
        st = 1;
        if (LAT > 1) begin
          n_cnt = LAT - 1; n_busy = 1;
        end
      end
    end
    n_stalls = (!pw && m_stalls < SAT) ? m_stalls + 1 : m_stalls;
    e_ctrl = {pw, iw, fl, ew, eb, mw, mb, wb, st, m_busy};
  endtask

  // One clock: compare against the model mid-cycle, then advance both at the edge.
  task automatic step(input string tag);
    @(negedge clk);
    model_eval();
    check({tag, ".ctrl"}, 32'(ctrl_obs), 32'(e_ctrl));
    check({tag, ".stalls"}, 32'(stall_cycles), 32'(m_stalls));
    @(posedge clk);
    m_cnt = n_cnt; m_stalls = n_stalls; m_busy = n_busy; m_wait = n_wait; m_pend = n_pend;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(negedge clk); #1;
    check("reset.ctrl", 32'(ctrl_obs), 32'(10'b1101010000));
    check("reset.stalls", 32'(stall_cycles), 32'd0);
    model_clear();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    model_clear();
    rst = 1'b1;
    #2;
    do_reset();

    // Load-use: lw $8 in EX, consumer of $8 in ID.
    id_exMemRead = 1; id_exRegWrite = 1; id_exRd = 5'd8; id_Rs = 5'd8;
    step("lu.stall");
    idle(); id_Rs = 5'd8;
    step("lu.go");
    check("lu.count", 32'(stall_cycles), 32'd1);

    // lw $5 feeding beq $5,$0: stall in EX then in MEM, then taken flush.
    idle(); id_isBranch = 1; id_Rs = 5'd5;
    id_exMemRead = 1; id_exRegWrite = 1; id_exRd = 5'd5;
    step("br.lu");
    id_exMemRead = 0; id_exRegWrite = 0; id_exRd = 0;
    ex_memMemRead = 1; ex_memRd = 5'd5;
    step("br.mem");
    ex_memMemRead = 0; ex_memRd = 0; branchTaken = 1;
    step("br.flush");
    idle();
    step("br.after");
    check("br.count", 32'(stall_cycles), 32'd3);

    // Plain mult occupies EX for LAT cycles.
    do_reset();
    id_isMulDiv = 1;
    step("mul.start");
    idle();
    for (int i = 0; i < 3; i++) step("mul.busy");
    step("mul.run");
    check("mul.count", 32'(stall_cycles), 32'd3);

    // Store waiting two cycles on data memory.
    do_reset();
    ex_memMemWrite = 1; dmem_ready = 0;
    step("sw.wait0");
    step("sw.wait1");
    dmem_ready = 1;
    step("sw.go");
    idle();
    step("sw.after");
    check("sw.count", 32'(stall_cycles), 32'd2);

    // Register 0 never forms a hazard.
    id_exMemRead = 1; id_exRegWrite = 1; id_exRd = 5'd0; id_Rs = 5'd0; id_Rt = 5'd0;
    id_usesRt = 1; id_isBranch = 1;
    step("r0.nostall");
    idle();
    check("r0.count", 32'(stall_cycles), 32'd2);

    // One-cycle memory wait inside mul/div occupancy.
    do_reset();
    id_isMulDiv = 1;
    step("mdw1.start");
    idle();
    step("mdw1.busy");
    ex_memMemWrite = 1; dmem_ready = 0;
    step("mdw1.hold");
    dmem_ready = 1;
    step("mdw1.release");
    idle();
    step("mdw1.busy2");
    step("mdw1.run");
    check("mdw1.count", 32'(stall_cycles), 32'd3);

    // Five-cycle wait outlasts the mul/div, returning straight to RUN.
    do_reset();
    id_isMulDiv = 1;
    step("mdw5.start");
    idle();
    step("mdw5.busy");
    ex_memMemRead = 1; ex_memRd = 5'd9; dmem_ready = 0;
    for (int i = 0; i < 5; i++) step("mdw5.hold");
    dmem_ready = 1;
    step("mdw5.release");
    idle();
    step("mdw5.run");
    check("mdw5.count", 32'(stall_cycles), 32'd6);

    // Asynchronous reset in the middle of MD_BUSY.
    do_reset();
    id_isMulDiv = 1;
    step("arst.start");
    idle();
    step("arst.busy");
    #2 rst = 1'b0;
    #1;
    check("arst.md_busy", 32'(md_busy), 32'd0);
    check("arst.stalls", 32'(stall_cycles), 32'd0);
    check("arst.pcWrite", 32'(pcWrite), 32'd1);
    rst = 1'b1;
    model_clear();
    step("arst.run0");
    step("arst.run1");

    // Random traffic over a small register set so dependencies are frequent.
    for (int i = 0; i < 400; i++) begin
      int r;
      if (i == 200) do_reset();
      id_Rs         = 5'($urandom_range(0, 3));
      id_Rt         = 5'($urandom_range(0, 3));
      id_exRd       = 5'($urandom_range(0, 3));
      ex_memRd      = 5'($urandom_range(0, 3));
      id_usesRt     = ($urandom_range(0, 1) == 1);
      id_isBranch   = ($urandom_range(0, 3) == 0);
      branchTaken   = id_isBranch && ($urandom_range(0, 1) == 1);
      id_isMulDiv   = !id_isBranch && ($urandom_range(0, 7) == 0);
      id_exMemRead  = ($urandom_range(0, 2) == 0);
      id_exRegWrite = id_exMemRead || ($urandom_range(0, 1) == 1);
      r = int'($urandom_range(0, 5));
      ex_memMemRead  = (r == 0);
      ex_memMemWrite = (r == 1);
      dmem_ready     = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
